// File: rtl/c499_response_checker.sv
`default_nettype none
// ============================================================================
// Module   : c499_response_checker
// Purpose  : Response side of the c499 vector flow. Captures one OUT_WIDTH-bit
//            output vector per valid beat, compares it with a preloaded
//            expected-response memory, counts mismatches, records the first
//            failing index and compacts every response into a MISR signature.
// Ports    : clk, rst (async, active-high)
//            exp_we / exp_addr / exp_wdata  - expected-memory load (IDLE only)
//            start                          - one-cycle run trigger
//            resp_valid / resp_data         - DUT response beat
//            busy, done, pass               - run status
//            err_count                      - mismatching beats (saturating)
//            first_err_valid / first_err_idx- first failing beat
//            misr_sig                       - response signature
// Revision : 1.0 - initial release
// ============================================================================
module c499_response_checker #(
  parameter int                 OUT_WIDTH     = 32,
  parameter int                 VEC_LENGTH    = 10,
  parameter int                 ADDR_WIDTH    = 4,
  parameter int                 ERR_CNT_WIDTH = 16,
  parameter logic [OUT_WIDTH-1:0] MISR_POLY   = 32'h04C11DB7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     exp_we,
  input  logic [ADDR_WIDTH-1:0]    exp_addr,
  input  logic [OUT_WIDTH-1:0]     exp_wdata,
  input  logic                     start,
  input  logic                     resp_valid,
  input  logic [OUT_WIDTH-1:0]     resp_data,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic                     first_err_valid,
  output logic [ADDR_WIDTH-1:0]    first_err_idx,
  output logic [OUT_WIDTH-1:0]     misr_sig
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  // One extra bit so VEC_LENGTH == 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0]   c_vec_len  = (ADDR_WIDTH+1)'(VEC_LENGTH);
  localparam logic [ADDR_WIDTH-1:0] c_last_idx = ADDR_WIDTH'(VEC_LENGTH - 1);

  logic [1:0]               r_state;
  logic [ADDR_WIDTH-1:0]    r_idx;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_pass;
  logic [ERR_CNT_WIDTH-1:0] r_err_count;
  logic                     r_first_err_valid;
  logic [ADDR_WIDTH-1:0]    r_first_err_idx;
  logic [OUT_WIDTH-1:0]     r_misr_sig;

  logic [OUT_WIDTH-1:0]     r_mem [VEC_LENGTH];

  logic                     w_mismatch;
  logic [ERR_CNT_WIDTH-1:0] w_err_next;
  logic [OUT_WIDTH-1:0]     w_misr_next;
  logic                     w_mem_wr;
  logic                     w_start_run;

  assign w_mem_wr    = (r_state == c_st_idle) && exp_we && ({1'b0, exp_addr} < c_vec_len);
  // A re-run from DONE behaves exactly like a start from IDLE.
  assign w_start_run = start && ((r_state == c_st_idle) || (r_state == c_st_done));
  assign w_mismatch  = (resp_data != r_mem[r_idx]);
  assign w_err_next  = (w_mismatch && (r_err_count != '1)) ? r_err_count + 1'b1 : r_err_count;
  assign w_misr_next = {r_misr_sig[OUT_WIDTH-2:0], 1'b0}
                     ^ (r_misr_sig[OUT_WIDTH-1] ? MISR_POLY : '0)
                     ^ resp_data;

  // Expected memory deliberately has no reset: it must survive rst so a
  // restarted run compares against the same vectors without a reload.
  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      r_mem[exp_addr] <= exp_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= c_st_idle;
      r_idx             <= '0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
      r_err_count       <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_idx   <= '0;
      r_misr_sig        <= '0;
    end else begin
      case (r_state)
        c_st_run: begin
          if (resp_valid) begin
            r_err_count <= w_err_next;
            r_misr_sig  <= w_misr_next;
            r_idx       <= r_idx + 1'b1;
            if (w_mismatch && !r_first_err_valid) begin
              r_first_err_valid <= 1'b1;
              r_first_err_idx   <= r_idx;
            end
            if (r_idx == c_last_idx) begin
              r_state <= c_st_done;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == '0);
            end
          end
        end
        default: begin
          // IDLE and DONE: hold results until a start launches a fresh run.
          if (w_start_run) begin
            r_state           <= c_st_run;
            r_idx             <= '0;
            r_busy            <= 1'b1;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_err_count       <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_idx   <= '0;
            r_misr_sig        <= '0;
          end
        end
      endcase
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err_count;
  assign first_err_valid = r_first_err_valid;
  assign first_err_idx   = r_first_err_idx;
  assign misr_sig        = r_misr_sig;

endmodule
`default_nettype wire

// File: tb/tb_c499_response_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_c499_response_checker
// Purpose  : Self-checking bench for c499_response_checker. Whole runs are
//            described by a table of {flip pattern, gap, expected results};
//            per-beat expectations go through a scoreboard queue. Reset abort,
//            memory retention and MISR corner cases are hand-written.
// Revision : 1.0 - initial release
// ============================================================================
module tb_c499_response_checker;

  localparam int          W    = 32;
  localparam int          N    = 10;
  localparam int          AW   = 4;
  localparam int          EW   = 16;
  localparam logic [W-1:0] POLY = 32'h04C11DB7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          exp_we = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [W-1:0]  exp_wdata = '0;
  logic          start = 1'b0;
  logic          resp_valid = 1'b0;
  logic [W-1:0]  resp_data = '0;
  logic          busy, done, pass, first_err_valid;
  logic [EW-1:0] err_count;
  logic [AW-1:0] first_err_idx;
  logic [W-1:0]  misr_sig;

  c499_response_checker #(
    .OUT_WIDTH(W), .VEC_LENGTH(N), .ADDR_WIDTH(AW),
    .ERR_CNT_WIDTH(EW), .MISR_POLY(POLY)
  ) dut (
    .clk(clk), .rst(rst),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_wdata(exp_wdata),
    .start(start), .resp_valid(resp_valid), .resp_data(resp_data),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_idx(first_err_idx),
    .misr_sig(misr_sig)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [W-1:0]  m_mem [N];
  logic [EW-1:0] m_err;
  logic          m_fv;
  logic [AW-1:0] m_fi;
  logic [W-1:0]  m_sig;
  int            m_idx;

  typedef struct {
    logic [EW-1:0] err;
    logic          fv;
    logic [AW-1:0] fi;
    logic [W-1:0]  sig;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string         name;
    logic [N-1:0]  flip;
    bit            gap;
    int            exp_err;
    bit            exp_fv;
    int            exp_fi;
    bit            exp_pass;
  } run_t;
  run_t runs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [W-1:0] data);
    exp_we    = 1'b1;
    exp_addr  = AW'(addr);
    exp_wdata = data;
    tick();
    exp_we = 1'b0;
    if (addr < N) m_mem[addr] = data;
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    m_err = '0; m_fv = 1'b0; m_fi = '0; m_sig = '0; m_idx = 0;
    check({tag, " busy after start"}, busy, 1);
    check({tag, " done after start"}, done, 0);
    check({tag, " err cleared"}, err_count, 0);
    check({tag, " sig cleared"}, misr_sig, 0);
  endtask

  // Drive one valid beat, push its expected effect, pop and compare the cycle after.
  task automatic beat(input string tag, input logic [W-1:0] d);
    exp_t e, got;
    if (d !== m_mem[m_idx]) begin
      if (m_err != '1) m_err = m_err + 1'b1;
      if (!m_fv) begin m_fv = 1'b1; m_fi = AW'(m_idx); end
    end
    m_sig = {m_sig[W-2:0], 1'b0} ^ (m_sig[W-1] ? POLY : '0) ^ d;
    m_idx++;
    e.err = m_err; e.fv = m_fv; e.fi = m_fi; e.sig = m_sig;
    sb.push_back(e);
    resp_valid = 1'b1;
    resp_data  = d;
    tick();
    resp_valid = 1'b0;
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 1, 0);
    end else begin
      got = sb.pop_front();
      check({tag, " err_count"}, err_count, got.err);
      check({tag, " first_err_valid"}, first_err_valid, got.fv);
      if (got.fv) check({tag, " first_err_idx"}, first_err_idx, got.fi);
      check({tag, " misr_sig"}, misr_sig, got.sig);
    end
  endtask

  task automatic do_run(input run_t r);
    logic [EW-1:0] s_err;
    logic [W-1:0]  s_sig;
    do_start(r.name);
    for (int k = 0; k < N; k++) begin
      if (r.gap && k > 0) begin
        tick();
        check({r.name, " done early (gap)"}, done, 0);
      end
      beat(r.name, m_mem[k] ^ (r.flip[k] ? 32'h1 : 32'h0));
      if (k < N-1) check({r.name, " done early"}, done, 0);
    end
    check({r.name, " done"}, done, 1);
    check({r.name, " busy at end"}, busy, 0);
    check({r.name, " pass"}, pass, r.exp_pass);
    check({r.name, " final err_count"}, err_count, r.exp_err);
    check({r.name, " final first_err_valid"}, first_err_valid, r.exp_fv);
    if (r.exp_fv) check({r.name, " final first_err_idx"}, first_err_idx, r.exp_fi);
    if (r.gap) begin
      s_err = err_count;
      s_sig = misr_sig;
      for (int j = 0; j < 3; j++) begin
        resp_valid = 1'b1;
        resp_data  = 32'hA5A5_0000 + j;
        tick();
      end
      resp_valid = 1'b0;
      check({r.name, " DONE ignores beats: err"}, err_count, s_err);
      check({r.name, " DONE ignores beats: sig"}, misr_sig, s_sig);
      check({r.name, " DONE ignores beats: done"}, done, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    runs[0] = '{"clean",      10'b0,          1'b0, 0,  1'b0, 0, 1'b1};
    runs[1] = '{"mismatch",   10'b0010001000, 1'b0, 2,  1'b1, 3, 1'b0};
    runs[2] = '{"gapped",     10'b0,          1'b1, 0,  1'b0, 0, 1'b1};
    runs[3] = '{"all_bad",    10'b1111111111, 1'b0, 10, 1'b1, 0, 1'b0};

    // Reset state
    repeat (2) tick();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset pass", pass, 0);
    check("reset err_count", err_count, 0);
    check("reset misr_sig", misr_sig, 0);
    rst = 1'b0;
    tick();
    check("post-reset busy", busy, 0);

    for (int k = 0; k < N; k++) load(k, k * 32'h0101_0101);
    load(12, 32'hFFFF_FFFF);  // out-of-range address, must be dropped

    for (int i = 0; i < 4; i++) do_run(runs[i]);

    // Write attempt in DONE must not land.
    exp_we = 1'b1; exp_addr = 4'd0; exp_wdata = 32'hDEAD_BEEF;
    tick();
    exp_we = 1'b0;

    // Reset mid-run after beat 5, then restart without reload.
    do_start("abort");
    for (int k = 0; k < 6; k++) beat("abort", m_mem[k]);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort err_count", err_count, 0);
    check("abort first_err_valid", first_err_valid, 0);
    check("abort misr_sig", misr_sig, 0);
    tick();
    rst = 1'b0;
    tick();
    check("abort busy after release", busy, 0);
    do_run(runs[0]);

    // MISR: zero memory, single set bit at beat 0 shifts up nine places.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int k = 0; k < N; k++) load(k, 32'h0);
    do_start("misr1");
    beat("misr1", 32'h1);
    for (int k = 1; k < N; k++) beat("misr1", 32'h0);
    check("misr1 sig", misr_sig, 32'h0000_0200);
    check("misr1 err", err_count, 1);
    check("misr1 first idx", first_err_idx, 0);
    check("misr1 pass", pass, 0);
    do_start("misr0");
    for (int k = 0; k < N; k++) beat("misr0", 32'h0);
    check("misr0 sig", misr_sig, 32'h0);
    check("misr0 pass", pass, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
